um245r_host: RTL and testbench
==============================

# um245r_host

Synthesizable host-side controller for the UM245R parallel FIFO. It sits between the CPU's UART port and the UM245R pins. It converts a byte-wide valid/ready transmit stream into WR strobes, and it turns `_RXF` availability into `_RD` strobes whose captured bytes are presented on a valid/ready receive stream. All device timing (strobe widths, data hold, flag blanking) is produced by cycle counters derived from parameters.

## Interface
- `WR_HIGH_CYC`, 2: cycles WR is held high with D driven (≥1).
- `WR_HOLD_CYC`, 1: cycles D stays driven after WR falls (≥1).
- `RD_LOW_CYC`, 4: cycles `_RD` is held low before D is sampled; must cover T3 (≥1).
- `BLANK_CYC`, 4: cycles after any strobe ends during which `_TXE`/`_RXF` are ignored; must cover T11 plus synchronizer latency (≥1).
- `clk` in 1: clock; all state updates on rising edge.
- `_MR` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: controller accepts `tx_data` this cycle.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer takes `rx_data` this cycle.
- `busy` out 1: state ≠ IDLE.
- `D` inout 8: device data bus; driven only in TX states, otherwise hi-z.
- `WR` out 1: write strobe; the device latches on its falling edge.
- `_RD` out 1: read strobe, active low.
- `_TXE` in 1: device can accept a write when low (asynchronous).
- `_RXF` in 1: device has data when low (asynchronous).

## Operation
- `_TXE` and `_RXF` each pass through a 2-flop synchronizer, giving `txe_s` and `rxf_s`. Synchronizers reset to 1 (not ready).
- FSM states are IDLE, TX_SETUP, TX_STROBE, TX_HOLD, RX_STROBE, RX_END and BLANK. A single down-counter is shared across states. Counter width is `$clog2(max param)+1`.
- In IDLE:
  - `can_tx = !txe_s`.
  - `can_rx = !rxf_s && !rx_valid`, so the holding register must be empty before a read starts.
  - `tx_ready = can_tx && (!can_rx || last_op==RX)`.
  - Arbitration is alternating: when both are possible, the operation opposite to `last_op` wins. `last_op` resets to TX, so the first tie goes to RX.
- TX path:
  - On `tx_valid && tx_ready`, latch `tx_data` into `tx_buf` and go to TX_SETUP.
  - TX_SETUP (1 cycle): D = `tx_buf`, WR = 0.
  - TX_STROBE (`WR_HIGH_CYC` cycles): WR = 1, D driven.
  - TX_HOLD (`WR_HOLD_CYC` cycles): WR = 0, D still driven.
  - Then go to BLANK and set `last_op` = TX.
- RX path:
  - In IDLE, when `can_rx` and RX wins arbitration, go to RX_STROBE.
  - RX_STROBE (`RD_LOW_CYC` cycles): `_RD` = 0. On the final cycle, capture D into `rx_data` and set `rx_valid`.
  - RX_END (1 cycle): `_RD` = 1. Then go to BLANK and set `last_op` = RX.
- BLANK: hold for `BLANK_CYC` cycles with flags ignored and `tx_ready` = 0, then return to IDLE.
- `rx_valid` clears on `rx_valid && rx_ready`. A capture and a consume never coincide, because a read only starts when `rx_valid` = 0.
- `tx_ready` is 0 outside IDLE.
- A `tx_valid` that is asserted and then dropped before acceptance has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: WR = 0, `_RD` = 1, D = hi-z, `tx_ready` = 0, `rx_valid` = 0, `rx_data` = 0, `busy` = 0.
  - Internal: state = IDLE, `last_op` = TX, synchronizers = 1.
- Reset asserted mid-operation forces strobes inactive and releases D in the same instant. Any partially read byte is discarded and the latched `tx_buf` is dropped.
- Flag-to-action latency: 2 cycles of synchronization, then the decision in IDLE on the next edge.
- TX occupancy, from acceptance to IDLE: `1 + WR_HIGH_CYC + WR_HOLD_CYC + BLANK_CYC` cycles; 8 with the defaults.
- RX occupancy, from the RX_STROBE entry edge to IDLE: `RD_LOW_CYC + 1 + BLANK_CYC` cycles; 9 with the defaults. `rx_valid` rises on the edge leaving RX_STROBE.
- D is driven stably from TX_SETUP through TX_HOLD, so it is valid on both sides of the WR falling edge.
- WR and `_RD` are never both active. D is never driven while `_RD` = 0.
- Back-to-back TX is only possible after BLANK and a fresh low `txe_s`. The device's T12 inactive period is absorbed by `_TXE` itself staying high.

## Test plan
- Reset check: hold `_MR` = 0 with `_TXE` = `_RXF` = 0 → WR = 0, `_RD` = 1, D = z, `tx_ready` = 0, `rx_valid` = 0. Release reset → `tx_ready` is still 0 for 2 cycles (synchronizer latency).
- Single TX: drive `tx_data` = 0x41 with `tx_valid` while `_TXE` = 0 → one WR high pulse of 2 cycles, D = 0x41 from 1 cycle before WR rises to 1 cycle after it falls. The device model records `41`. Next acceptance comes no earlier than 8 cycles later.
- Single RX: load the device with "Hi" and keep `rx_ready` = 0 → exactly one `_RD` low pulse of 4 cycles, then `rx_valid` = 1 with `rx_data` = 0x48. No second read occurs until a cycle with `rx_ready` = 1, after which a read yields 0x69.
- Arbitration: hold `tx_valid` (0x55) with `_TXE` = 0, and `_RXF` = 0 with `rx_ready` = 1 → operation order is RX, TX, RX, TX, and the strobes never overlap.
- Reset mid-read: assert `_MR` on the 2nd cycle of RX_STROBE → `_RD` = 1 immediately, `rx_valid` = 0. After release, the device sees a normal read with no `_RD` low while `_RXF` is high.
- Blanking: device raises `_TXE` 25 ns after WR falls → the controller issues no second WR before `_TXE` returns low, and the device never reports a write while not ready.

Source files
------------

// File: rtl/um245r_host.sv
// um245r_host: bridges valid/ready byte streams to UM245R WR/_RD strobes,
// with counter-timed strobes and post-strobe flag blanking.
module um245r_host #(
  parameter int WR_HIGH_CYC = 2,
  parameter int WR_HOLD_CYC = 1,
  parameter int RD_LOW_CYC  = 4,
  parameter int BLANK_CYC   = 4
) (
  input  logic       clk,
  input  logic       _MR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  inout  wire  [7:0] D,
  output logic       WR,
  output logic       _RD,
  input  logic       _TXE,
  input  logic       _RXF
);
  localparam int M1 = WR_HIGH_CYC > WR_HOLD_CYC ? WR_HIGH_CYC : WR_HOLD_CYC;
  localparam int M2 = RD_LOW_CYC > BLANK_CYC ? RD_LOW_CYC : BLANK_CYC;
  localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
  typedef enum logic [2:0] {IDLE, TX_SETUP, TX_STROBE, TX_HOLD, RX_STROBE, RX_END, BLANK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] txe_q, rxf_q;
  logic [7:0] tx_buf;
  logic last_rx, drive, can_tx, can_rx, rx_go;
  assign D = drive ? tx_buf : 8'hzz;
  assign busy = state != IDLE;
  always_comb begin
    can_tx = !txe_q[1];
    can_rx = !rxf_q[1] && !rx_valid;
    tx_ready = state == IDLE && can_tx && (!can_rx || last_rx);
    rx_go = can_rx && !(tx_valid && tx_ready);
  end
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      txe_q <= 2'b11;
      rxf_q <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      tx_buf <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      last_rx <= 1'b0;
      WR <= 1'b0;
      _RD <= 1'b1;
      drive <= 1'b0;
    end else begin
      txe_q <= {txe_q[0], _TXE};
      rxf_q <= {rxf_q[0], _RXF};
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (tx_valid && tx_ready) begin
            tx_buf <= tx_data;
            drive <= 1'b1;
            state <= TX_SETUP;
          end else if (rx_go) begin
            _RD <= 1'b0;
            cnt <= CW'(RD_LOW_CYC - 1);
            state <= RX_STROBE;
          end
        TX_SETUP: begin
          WR <= 1'b1;
          cnt <= CW'(WR_HIGH_CYC - 1);
          state <= TX_STROBE;
        end
        TX_STROBE:
          if (cnt == '0) begin
            WR <= 1'b0;
            cnt <= CW'(WR_HOLD_CYC - 1);
            state <= TX_HOLD;
          end else cnt <= cnt - CW'(1);
        TX_HOLD:
          if (cnt == '0) begin
            drive <= 1'b0;
            last_rx <= 1'b0;
            cnt <= CW'(BLANK_CYC - 1);
            state <= BLANK;
          end else cnt <= cnt - CW'(1);
        RX_STROBE:
          if (cnt == '0) begin
            rx_data <= D;
            rx_valid <= 1'b1;
            _RD <= 1'b1;
            state <= RX_END;
          end else cnt <= cnt - CW'(1);
        RX_END: begin
          last_rx <= 1'b1;
          cnt <= CW'(BLANK_CYC - 1);
          state <= BLANK;
        end
        BLANK:
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_um245r_host.sv
// tb_um245r_host: directed bench with a behavioural UM245R device model.
module tb_um245r_host;
  logic clk = 0, mr_n = 1;
  logic [7:0] tx_data = 0;
  logic tx_valid = 0, rx_ready = 0;
  wire tx_ready, rx_valid, busy, wr, rd_n;
  wire [7:0] rx_data;
  wire [7:0] d_bus;
  logic tx_en = 0, tx_busy = 0, rx_busy = 0, dev_drive = 0, probe = 0, rd_act = 0;
  logic [7:0] dev_data = 0;
  logic [7:0] rx_mem [16];
  logic [7:0] tx_log [64];
  int ops [64];
  int rx_head = 0, rx_tail = 0, tx_n = 0, op_n = 0;
  int bad_wr = 0, bad_rd = 0, overlap = 0, rd_pulses = 0;
  int wr_len = 0, rd_len = 0, last_wr_len = 0, last_rd_len = 0;
  logic wr_prev = 0, rdl_prev = 0;
  logic [7:0] d_prev = 0, d_before = 0, d_after = 0;
  int errors = 0, checks = 0;
  wire txe_n = !tx_en || tx_busy;
  wire rxf_n = (rx_head == rx_tail) || rx_busy;
  assign d_bus = probe ? 8'h5A : (dev_drive ? dev_data : 8'hzz);

  um245r_host dut (
    .clk(clk), ._MR(mr_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .D(d_bus), .WR(wr), ._RD(rd_n), ._TXE(txe_n), ._RXF(rxf_n)
  );

  always #5 clk = ~clk;

  // Device write side: latch on WR fall, then go not-ready 25 ns later for 150 ns.
  always @(negedge wr) if (mr_n) begin
    if (txe_n) bad_wr++;
    tx_log[tx_n % 64] = d_bus;
    tx_n++;
  end
  always @(negedge wr) if (mr_n) begin
    #25 tx_busy = 1;
    #150 tx_busy = 0;
  end

  // Device read side: present data shortly after _RD falls, pop on _RD rise.
  always begin
    @(negedge rd_n);
    if (mr_n) begin
      if (rxf_n) bad_rd++;
      rd_act = 1;
      #8;
      dev_data = rx_mem[rx_head % 16];
      dev_drive = 1;
      @(posedge rd_n);
      dev_drive = 0;
      rd_act = 0;
      rx_head++;
      rx_busy = 1;
      #50 rx_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (wr && !rd_n) overlap++;
    if (wr && !wr_prev) begin
      ops[op_n % 64] = 1;
      op_n++;
      d_before = d_prev;
    end
    if (!wr && wr_prev) begin
      last_wr_len = wr_len;
      d_after = d_bus;
    end
    if (wr) wr_len = wr_prev ? wr_len + 1 : 1;
    if (!rd_n && !rdl_prev) begin
      ops[op_n % 64] = 2;
      op_n++;
      rd_pulses++;
    end
    if (rd_n && rdl_prev) last_rd_len = rd_len;
    if (!rd_n) rd_len = rdl_prev ? rd_len + 1 : 1;
    d_prev = d_bus;
    wr_prev = wr;
    rdl_prev = !rd_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int t = 0;
    tx_data = b;
    tx_valid = 1;
    while (!tx_ready && t < 300) begin
      tick;
      t++;
    end
    chk("send_ready", tx_ready, 1);
    @(posedge clk);
    acc = int'($time / 10);
    #1 tx_valid = 0;
    tick;
  endtask

  task automatic wait_rxv;
    int t = 0;
    while (!rx_valid && t < 200) begin
      tick;
      t++;
    end
    chk("rxv_wait", rx_valid, 1);
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 200) begin
      tick;
      t++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_tail % 16] = b;
    rx_tail++;
  endtask

  initial begin
    int a1, a2, rb, ob, t;
    #1 mr_n = 0;
    tx_en = 1;
    probe = 1;
    repeat (3) tick;
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd_n, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d_released", d_bus, 8'h5A);
    probe = 0;
    @(negedge clk);
    mr_n = 1;
    tick;
    chk("sync_lat1", tx_ready, 0);
    tick;
    chk("sync_lat2", tx_ready, 1);

    send(8'h41, a1);
    repeat (5) tick;
    chk("tx_count1", tx_n, 1);
    chk("tx_byte1", tx_log[0], 8'h41);
    chk("tx_wr_len", last_wr_len, 2);
    chk("tx_d_before", d_before, 8'h41);
    chk("tx_d_after", d_after, 8'h41);
    send(8'h42, a2);
    chk("tx_gap_ge8", a2 - a1 >= 8, 1);
    repeat (10) tick;
    chk("tx_count2", tx_n, 2);
    chk("tx_byte2", tx_log[1], 8'h42);
    wait_idle;

    rb = rd_pulses;
    push_rx(8'h48);
    push_rx(8'h69);
    wait_rxv;
    chk("rx_byte1", rx_data, 8'h48);
    chk("rx_rd_len", last_rd_len, 4);
    chk("rx_pulses1", rd_pulses - rb, 1);
    repeat (30) tick;
    chk("rx_stall_pulses", rd_pulses - rb, 1);
    chk("rx_stall_valid", rx_valid, 1);
    rx_ready = 1;
    tick;
    rx_ready = 0;
    wait_rxv;
    chk("rx_byte2", rx_data, 8'h69);
    chk("rx_pulses2", rd_pulses - rb, 2);
    rx_ready = 1;
    tick;
    wait_idle;
    repeat (30) tick;

    // Fresh reset so last_op is TX and the first tie goes to RX.
    mr_n = 0;
    tick;
    push_rx(8'h01);
    push_rx(8'h02);
    tx_data = 8'h55;
    tx_valid = 1;
    tick;
    ob = op_n;
    mr_n = 1;
    t = 0;
    while (op_n - ob < 4 && t < 400) begin
      tick;
      t++;
    end
    tx_valid = 0;
    chk("arb_op0", ops[ob % 64], 2);
    chk("arb_op1", ops[(ob + 1) % 64], 1);
    chk("arb_op2", ops[(ob + 2) % 64], 2);
    chk("arb_op3", ops[(ob + 3) % 64], 1);
    wait_idle;
    chk("arb_rx_last", rx_data, 8'h02);
    chk("arb_tx_last", tx_log[(tx_n - 1) % 64], 8'h55);
    repeat (30) tick;

    rx_ready = 0;
    push_rx(8'h33);
    push_rx(8'h44);
    t = 0;
    while (rd_n && t < 200) begin
      tick;
      t++;
    end
    chk("mid_rd_started", rd_n, 0);
    tick;
    mr_n = 0;
    #1;
    chk("mid_rd_released", rd_n, 1);
    chk("mid_rx_valid", rx_valid, 0);
    chk("mid_wr", wr, 0);
    tick;
    mr_n = 1;
    wait_rxv;
    chk("mid_next_byte", rx_data, 8'h44);
    chk("mid_rd_len", last_rd_len, 4);

    repeat (5) tick;
    chk("no_bad_wr", bad_wr, 0);
    chk("no_bad_rd", bad_rd, 0);
    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
